alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: Parameter N, default 8, SHALL set the operand and result width in bits.
REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004: req_valid  input  2  per-requester operation request; index 0 and index 1 are the two requesters.
REQ-005: req_ready  output  2  per-requester accept; a request transfers when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-006: req_a0, req_b0, req_a1, req_b1  input  N each  operands of requester 0 and requester 1.
REQ-007: req_op0, req_op1  input  2 each  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008: alu_a, alu_b  output  N  operands driven to the shared combinational ALU.
REQ-009: alu_ctrl  output  2  opcode driven to the shared ALU.
REQ-010: alu_result  input  N  result returned by the shared ALU.
REQ-011: alu_flags  input  4  ALU flags in the order {V, C, Neg, Z}.
REQ-012: rsp_valid  output  2  per-requester response valid; at most one bit SHALL be high.
REQ-013: rsp_ready  input  2  per-requester response accept.
REQ-014: rsp_result  output  N  registered result; shared by both requesters and qualified by rsp_valid.
REQ-015: rsp_flags  output  4  registered {V, C, Neg, Z}; qualified by rsp_valid.
REQ-016: busy  output  1  high in any state other than IDLE.

Function
REQ-017: The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018: In IDLE, grant selection:
- one req_valid bit high -> that requester is granted;
- both high -> the requester indexed by rr_ptr is granted;
- neither high -> no grant.
REQ-019: req_ready[i] SHALL be combinational and equal (state==IDLE) & grant[i]; it SHALL be 0 in EXEC and RESP.
REQ-020: On a transfer, the block SHALL:
- register the granted requester's operands and opcode into alu_a, alu_b and alu_ctrl;
- record the owner index;
- set rr_ptr to the other index;
- move to EXEC.
REQ-021: alu_a, alu_b and alu_ctrl SHALL come only from registers and SHALL hold their values until the next transfer.
REQ-022: In EXEC, the block SHALL, in exactly one cycle:
- capture alu_result into rsp_result and alu_flags into rsp_flags;
- move to RESP.
REQ-023: In RESP, rsp_valid[owner] SHALL be high; rsp_result and rsp_flags SHALL be stable until the response transfers.
REQ-024: When rsp_valid[owner] and rsp_ready[owner] are both high, the block SHALL return to IDLE.
REQ-025: rsp_ready of the non-owner requester SHALL be ignored.
REQ-026: Latency: a transfer at edge k SHALL produce rsp_valid high from edge k+2.
REQ-027: Minimum issue interval: with rsp_ready held high, one operation SHALL complete every 3 cycles.
REQ-028: A request arriving in EXEC or RESP SHALL wait; the requester SHALL hold req_valid and its operands.
REQ-029: Fairness: under continuous requests from both requesters, grants SHALL alternate 0,1,0,1; neither requester SHALL wait more than one operation.
REQ-030: Arithmetic, width and flag semantics belong to the ALU; the block SHALL pass alu_result and alu_flags unmodified.

Reset
REQ-031: While rst_n is low, the block SHALL hold: state IDLE, rr_ptr 0, owner 0, alu_a 0, alu_b 0, alu_ctrl 00, rsp_result 0, rsp_flags 0, rsp_valid 00, busy 0.
REQ-032: Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued; the first grant after release SHALL follow REQ-018 with rr_ptr=0.

Verification
REQ-033: Single request: req_valid=01, a0=0x7F, b0=0x01, op0=ADD, bench ALU attached -> req_ready=01 that cycle; 2 cycles later rsp_valid=01, rsp_result=0x80, rsp_flags Neg=1, Z=0.
REQ-034: Simultaneous requests after reset: req_valid=11, op0=SUB 0x05-0x05, op1=OR 0x0F|0xF0 -> requester 0 served first (rsp_result=0x00, Z=1); then requester 1 (rsp_result=0xFF, Neg=1).
REQ-035: Backpressure: hold rsp_ready=00 for 10 cycles in RESP -> rsp_valid, rsp_result and rsp_flags stable, req_ready=00, busy=1; rsp_ready=01 -> IDLE next cycle.
REQ-036: Fairness stress: both requesters valid for 12 operations, rsp_ready=11 -> grant order 0,1,0,1,...; an operation completes every 3 cycles.
REQ-037: Reset mid-operation: assert rst_n=0 during EXEC -> rsp_valid never asserts for that operation; all outputs match REQ-031; after release, a request from 1 alone is granted immediately.
REQ-038: Non-owner ready: owner=1 in RESP, rsp_ready=01 -> no state change; rsp_valid remains 10.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight at a time: IDLE -> EXEC (capture ALU outputs) -> RESP (hold until accepted).
module alu_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [1:0]   req_op0,
  input  logic [1:0]   req_op1,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         rr_ptr_q, rr_ptr_d;
  logic         owner_q, owner_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;

  logic [1:0] grant;
  logic       grant_idx;
  logic       req_fire;
  logic       rsp_fire;

  // rr_ptr only breaks ties; a lone requester is always granted.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign grant_idx = grant[1];
  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign req_fire  = |(req_ready & req_valid);
  assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_fire  = (state_q == RESP) && rsp_ready[owner_q];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          alu_a_d    = grant_idx ? req_a1  : req_a0;
          alu_b_d    = grant_idx ? req_b1  : req_b0;
          alu_ctrl_d = grant_idx ? req_op1 : req_op0;
          owner_d    = grant_idx;
          rr_ptr_d   = ~grant_idx;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 2'b00;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an 8-bit reference ALU attached; flags are {V, C, Neg, Z}.
module tb_alu_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]   req_op0, req_op1;
  logic [N-1:0] alu_a, alu_b;
  logic [1:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         busy;

  int tests;
  int failed;
  int ops;
  int last_cyc;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: C is the carry out (no-borrow for SUB); V and C are 0 for logic ops.
  logic [N:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_flags  = 4'b0000;
    case (alu_ctrl)
      2'b00: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[N-1:0];
        alu_flags[2] = sum[N];
        alu_flags[3] = (alu_a[N-1] == alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
      end
      2'b01: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
        alu_result   = sum[N-1:0];
        alu_flags[2] = sum[N];
        alu_flags[3] = (alu_a[N-1] != alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
      end
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    alu_flags[1] = alu_result[N-1];
    alu_flags[0] = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},       32'(busy),       32'h0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),  32'h0);
    check({tag, "_req_ready"},  32'(req_ready),  32'h0);
    check({tag, "_alu_a"},      32'(alu_a),      32'h0);
    check({tag, "_alu_b"},      32'(alu_b),      32'h0);
    check({tag, "_alu_ctrl"},   32'(alu_ctrl),   32'h0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'h0);
    check({tag, "_rsp_flags"},  32'(rsp_flags),  32'h0);
  endtask

  initial begin
    tests = 0; failed = 0;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_op0 = 2'b00; req_op1 = 2'b00;

    repeat (2) @(negedge clk);
    #1 check_reset_state("reset");
    rst_n = 1'b1;

    // Single request: 0x7F + 0x01
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 8'h7F; req_b0 = 8'h01; req_op0 = 2'b00; rsp_ready = 2'b01;
    #1 check("single_req_ready", 32'(req_ready), 32'h1);
    check("single_idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("single_exec_busy", 32'(busy), 32'h1);
    check("single_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    check("single_alu_a", 32'(alu_a), 32'h7F);
    check("single_alu_b", 32'(alu_b), 32'h01);
    check("single_alu_ctrl", 32'(alu_ctrl), 32'h0);
    @(negedge clk);
    #1 check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_result", 32'(rsp_result), 32'h80);
    check("single_rsp_flags", 32'(rsp_flags), 32'hA);
    @(negedge clk);
    #1 check("single_done_busy", 32'(busy), 32'h0);
    check("single_done_rsp_valid", 32'(rsp_valid), 32'h0);

    // Simultaneous requests after reset: requester 0 first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_a0 = 8'h05; req_b0 = 8'h05; req_op0 = 2'b01;
    req_a1 = 8'h0F; req_b1 = 8'hF0; req_op1 = 2'b11;
    rsp_ready = 2'b01;
    #1 check("both_first_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b10;
    #1 check("both_exec_req_ready", 32'(req_ready), 32'h0);
    check("both_alu_ctrl0", 32'(alu_ctrl), 32'h1);
    @(negedge clk);
    #1 check("both_rsp0_valid", 32'(rsp_valid), 32'h1);
    check("both_rsp0_result", 32'(rsp_result), 32'h00);
    check("both_rsp0_flags", 32'(rsp_flags), 32'h5);
    @(negedge clk);
    #1 check("both_second_grant", 32'(req_ready), 32'h2);
    check("both_idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("both_alu_ctrl1", 32'(alu_ctrl), 32'h3);
    check("both_alu_a1", 32'(alu_a), 32'h0F);
    @(negedge clk);
    #1 check("both_rsp1_valid", 32'(rsp_valid), 32'h2);
    check("both_rsp1_result", 32'(rsp_result), 32'hFF);
    check("both_rsp1_flags", 32'(rsp_flags), 32'h2);

    // Owner is 1 while rsp_ready is still 01: must stay in RESP
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("nonowner_rsp_valid", 32'(rsp_valid), 32'h2);
      check("nonowner_busy", 32'(busy), 32'h1);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    #1 check("nonowner_release_busy", 32'(busy), 32'h0);
    check("nonowner_release_valid", 32'(rsp_valid), 32'h0);

    // Backpressure: 0xF0 + 0x20 held in RESP for 10 cycles
    req_valid = 2'b01; req_a0 = 8'hF0; req_b0 = 8'h20; req_op0 = 2'b00; rsp_ready = 2'b00;
    #1 check("bp_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b10; req_a1 = 8'h03; req_b1 = 8'h01; req_op1 = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_result", 32'(rsp_result), 32'h10);
      check("bp_rsp_flags", 32'(rsp_flags), 32'h4);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    #1 check("bp_release_busy", 32'(busy), 32'h0);
    check("bp_waiting_grant", 32'(req_ready), 32'h2);
    req_valid = 2'b00; rsp_ready = 2'b00;

    // Fairness: both requesters continuously valid for 12 operations
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a0 = 8'h11; req_b0 = 8'h22; req_op0 = 2'b00;
    req_a1 = 8'hF0; req_b1 = 8'h3C; req_op1 = 2'b10;
    req_valid = 2'b11; rsp_ready = 2'b11;
    ops = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 60 && ops < 12; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        check("fair_grant", 32'(req_ready), (ops % 2 == 0) ? 32'h1 : 32'h2);
        if (ops > 0) check("fair_interval", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        ops++;
      end
      if (rsp_valid == 2'b01) begin
        check("fair_rsp0_result", 32'(rsp_result), 32'h33);
        check("fair_rsp0_flags", 32'(rsp_flags), 32'h0);
      end else if (rsp_valid == 2'b10) begin
        check("fair_rsp1_result", 32'(rsp_result), 32'h30);
        check("fair_rsp1_flags", 32'(rsp_flags), 32'h0);
      end
      @(negedge clk);
    end
    check("fair_ops_done", 32'(ops), 32'd12);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset during EXEC discards the operation
    req_valid = 2'b01; req_a0 = 8'hAA; req_b0 = 8'h55; req_op0 = 2'b11;
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("midrst_exec_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk);
    #1 check("midrst_held_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b10; req_a1 = 8'hFF; req_b1 = 8'h01; req_op1 = 2'b00; rsp_ready = 2'b10;
    #1 check("midrst_after_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("midrst_after_exec_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1 check("midrst_after_rsp_valid", 32'(rsp_valid), 32'h2);
    check("midrst_after_result", 32'(rsp_result), 32'h00);
    check("midrst_after_flags", 32'(rsp_flags), 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
